hbridge_deadtime_gen: RTL



---
 rtl/hbridge_deadtime_gen.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/hbridge_deadtime_gen.sv
// hbridge_deadtime_gen
//
// Gate-signal generator for N_CH full H-bridges. Each channel turns a 3-level
// command (+1 / 0 / -1) into four gate drives. A programmable dead interval is
// inserted on every level change. During that interval, legs that change are
// held off and legs that stay the same keep their value.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   CE            clock enable; channel state advances only when high
//   deadtime      dead interval setting, interval = deadtime+1 enabled cycles
//   cmd           per-channel level code, channel i = cmd[2i+1:2i]
//                 (01 = +1, 00 = 0, 11 = -1, 10 = hold)
//   pol           per-channel mapping select (1 swaps the +1/-1 patterns)
//   fault         emergency shutdown request, level sensitive
//   fault_clr     clears the latched fault when fault is low
//   gate          channel i = gate[4i+3:4i] = {A_hi, A_lo, B_hi, B_lo}
//   busy          channel i is in OFF or DEAD
//   fault_latched fault latch state
//
// Build option:
//   HBG_FAULT_EN  when defined, enables the fault latch. When undefined,
//                 fault/fault_clr are ignored and fault_latched is tied to 0.
//
// gate and busy are registered. There is no combinational path from cmd, pol
// or fault to the outputs.
module hbridge_deadtime_gen #(
  parameter int unsigned N_CH = 2,
  parameter int unsigned DT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                CE,
  input  logic [DT_W-1:0]     deadtime,
  input  logic [2*N_CH-1:0]   cmd,
  input  logic [N_CH-1:0]     pol,
  input  logic                fault,
  input  logic                fault_clr,
  output logic [4*N_CH-1:0]   gate,
  output logic [N_CH-1:0]     busy,
  output logic                fault_latched
);

  typedef enum logic [1:0] {StOff, StDead, StSteady} ch_state_e;

  localparam logic [1:0] LvlPos   = 2'b01;
  localparam logic [1:0] LvlZero  = 2'b00;
  localparam logic [1:0] LvlNeg   = 2'b11;
  localparam logic [1:0] CodeHold = 2'b10;

  // Level pattern {A_hi, A_lo, B_hi, B_lo}; sec selects the swapped mapping.
  function automatic logic [3:0] level_pat(input logic [1:0] lvl, input logic sec);
    logic [3:0] p;
    case (lvl)
      LvlPos:  p = sec ? 4'b1001 : 4'b0110;
      LvlNeg:  p = sec ? 4'b0110 : 4'b1001;
      default: p = 4'b0101;
    endcase
    return p;
  endfunction

  logic fault_hold; // latched fault: keep every channel in OFF
  logic fault_kill; // force every channel to OFF on this edge

`ifdef HBG_FAULT_EN
  logic fault_latched_q;

  // Fault path runs every clock, independent of CE; fault beats fault_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_latched_q <= 1'b0;
    end else if (fault) begin
      fault_latched_q <= 1'b1;
    end else if (fault_clr) begin
      fault_latched_q <= 1'b0;
    end
  end

  assign fault_hold    = fault_latched_q;
  assign fault_kill    = fault;
  assign fault_latched = fault_latched_q;
`else
  logic unused_fault;
  assign unused_fault  = fault ^ fault_clr;
  assign fault_hold    = 1'b0;
  assign fault_kill    = 1'b0;
  assign fault_latched = 1'b0;
`endif

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    ch_state_e       st_q;
    logic [1:0]      lvl_q;
    logic [1:0]      tgt_lvl_q;
    logic [3:0]      pat_q;      // pattern of the current steady level
    logic [3:0]      tgt_pat_q;  // pattern captured when the transition started
    logic [3:0]      gate_q;
    logic            busy_q;
    logic [DT_W-1:0] cnt_q;

    logic [1:0] cmd_ch;
    logic       cmd_valid;
    logic [1:0] boot_lvl;
    logic [3:0] new_pat;
    logic [3:0] boot_pat;

    assign cmd_ch    = cmd[2*i +: 2];
    assign cmd_valid = (cmd_ch != CodeHold);
    assign boot_lvl  = cmd_valid ? cmd_ch : LvlZero;
    // pol is only sampled here, when a target is captured. A pol change
    // therefore takes effect through the next transition.
    assign new_pat   = level_pat(cmd_ch, pol[i]);
    assign boot_pat  = level_pat(boot_lvl, pol[i]);

    always_ff @(posedge clk) begin
      if (rst || fault_kill) begin
        st_q      <= StOff;
        lvl_q     <= LvlZero;
        tgt_lvl_q <= LvlZero;
        pat_q     <= 4'b0000;
        tgt_pat_q <= 4'b0000;
        gate_q    <= 4'b0000;
        busy_q    <= 1'b1;
        cnt_q     <= '0;
      end else if (CE && !fault_hold) begin
        case (st_q)
          StOff: begin
            // The OFF cycle counts as the first blank cycle. This makes
            // bootstrap take deadtime+1 enabled cycles, the same as a
            // normal transition.
            tgt_lvl_q <= boot_lvl;
            tgt_pat_q <= boot_pat;
            if (deadtime == '0) begin
              st_q   <= StSteady;
              lvl_q  <= boot_lvl;
              pat_q  <= boot_pat;
              gate_q <= boot_pat;
              busy_q <= 1'b0;
              cnt_q  <= '0;
            end else begin
              st_q   <= StDead;
              gate_q <= 4'b0000;
              busy_q <= 1'b1;
              cnt_q  <= DT_W'(1);
            end
          end
          StSteady: begin
            if (cmd_valid && (cmd_ch != lvl_q)) begin
              st_q      <= StDead;
              tgt_lvl_q <= cmd_ch;
              tgt_pat_q <= new_pat;
              // Changing legs go fully off; unchanged legs keep driving.
              gate_q    <= pat_q & new_pat;
              busy_q    <= 1'b1;
              cnt_q     <= '0;
            end
          end
          StDead: begin
            // >= so a lowered deadtime ends the interval at once, with no wrap.
            if (cnt_q >= deadtime) begin
              st_q   <= StSteady;
              lvl_q  <= tgt_lvl_q;
              pat_q  <= tgt_pat_q;
              gate_q <= tgt_pat_q;
              busy_q <= 1'b0;
              cnt_q  <= '0;
            end else begin
              cnt_q <= cnt_q + DT_W'(1);
            end
          end
          default: begin
            st_q   <= StOff;
            gate_q <= 4'b0000;
            busy_q <= 1'b1;
            cnt_q  <= '0;
          end
        endcase
      end
    end

    assign gate[4*i +: 4] = gate_q;
    assign busy[i]        = busy_q;
  end

endmodule
